imm_packer: RTL
===============

# imm_packer

Instruction-word packer for the RV32I pipeline and the inverse of the immediate extender. It accepts decoded fields and a 32-bit signed immediate for I, S, B or shift formats, range-checks the immediate, and packs it into a 32-bit instruction word. It is pipelined behind a valid/ready handshake and sequentially assigns instruction-memory addresses, so it can feed the instruction-memory loader and the self-checking assembler in the test environment.

## Interface
Parameters:
- ADDR_W, 32, width of the output address counter
- BASE_ADDR, 0, address of the first word after reset or clear

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- clear  in  1  synchronous restart: flush pipeline, reload address, zero err_count
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid && in_ready
- in_fmt  in  2  00 I, 01 S, 10 B, 11 shift (same encoding as the extender's Imm select)
- in_opcode  in  7  opcode field
- in_funct3  in  3  funct3 field
- in_funct7  in  7  upper field, shift format only
- in_rd, in_rs1, in_rs2  in  5 each  register fields
- in_imm  in  32  signed immediate (byte offset for B)
- out_valid  out  1  packed word valid
- out_ready  in  1  consumer ready
- out_instr  out  32  packed instruction
- out_addr  out  ADDR_W  address of out_instr
- out_err  out  1  immediate for this word was out of range
- err_count  out  16  saturating count of delivered words with out_err

## Operation
- Packing (instr[31:0]):
  - I: {imm[11:0], rs1, f3, rd, op}
  - S: {imm[11:5], rs2, rs1, f3, imm[4:0], op}
  - B: {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op}
  - shift: {funct7, imm[4:0], rs1, f3, rd, op}
- Unused register fields are ignored.
- Range check:
  - I/S: imm[31:11] all equal.
  - B: imm[31:12] all equal and imm[0]==0.
  - shift: imm[31:5]==0.
  - On a failed check the word is still emitted with truncated fields, and out_err=1.
- Round trip: feeding out_instr[31:7] to the extender with the same format code returns in_imm whenever out_err=0.
- Address: a counter starts at BASE_ADDR. Each accepted request takes the current value, then the counter adds 4, wrapping modulo 2^ADDR_W.
- err_count increments on out_valid && out_ready && out_err and saturates at 0xFFFF.

## Timing
- Two register stages:
  - S1 captures the fields, the address and the range-check result.
  - S2 holds the packed word and drives the out_* ports.
- Latency: accept at edge N, out_valid at N+2 with no stall. Throughput is 1 word per cycle.
- Stall rules:
  - S2 advances when !out_valid || out_ready.
  - S1 advances when S2 advances or S2 is empty.
  - in_ready = !s1_valid || s1_advance, so it is combinational from out_ready.
- While stalled, out_instr, out_addr and out_err hold stable. No word is lost or duplicated, and order is preserved.
- clear:
  - in_ready=0 in the clear cycle.
  - Next cycle: out_valid=0, counter=BASE_ADDR, err_count=0.
  - clear has priority over a simultaneous handshake; that request is dropped.
- Reset values: out_valid=0, in_ready=1 (after reset releases), out_instr=0, out_addr=BASE_ADDR, out_err=0, err_count=0, both stage valids 0. Reset mid-stream discards all in-flight words.

## Structure
- Shared package: format codes (FMT_I=2'b00, FMT_S, FMT_B, FMT_SHIFT), opcode constants, and a range-check function. The extender uses the same format codes.
- One sub-module: imm_pack_fields, combinational, producing {instr, err} from fmt/fields/imm. The pipeline, handshake, address counter and err_count live in imm_packer.

## Test plan
- I: op 0x13, f3 0, rd 1, rs1 0, imm 5 → out_instr 0x00500093, out_addr 0, out_err 0, at the second edge after accept.
- S and B back-to-back:
  - sw: op 0x23, f3 2, rs1 1, rs2 2, imm 8 → 0x0020A423, addr 4.
  - beq: op 0x63, f3 0, rs1 1, rs2 2, imm −4 → 0xFE208EE3, addr 8.
- shift: op 0x13, f3 1, rd 3, rs1 3, f7 0, imm 4 → 0x00419193. Then imm 32 → out_err 1, err_count 1.
- Range errors:
  - I imm 2048 → 0x80000093 with out_err 1.
  - B imm 6 (legal) → out_err 0.
  - B imm 7 → out_err 1.
- Backpressure: stream 4 requests with out_ready low for 3 cycles → in_ready drops after 2 held words; all 4 arrive in order at addresses 0, 4, 8, 12 with stable outputs during the stall.
- Control: clear asserted mid-stream, and rst_n pulsed mid-stream → pipeline empties next cycle, the following word has addr BASE_ADDR, err_count=0. A 65536+ error stream saturates err_count at 0xFFFF.

Source files
------------

// File: rtl/imm_packer_pkg.sv
// rtl/imm_packer_pkg.sv - format codes, opcodes and immediate range check shared with the extender
package imm_packer_pkg;

  typedef enum logic [1:0] {
    FMT_I     = 2'b00,
    FMT_S     = 2'b01,
    FMT_B     = 2'b10,
    FMT_SHIFT = 2'b11
  } imm_fmt_e;

  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JALR   = 7'h67;

  localparam logic [15:0] ERR_COUNT_MAX = 16'hFFFF;

  // True when imm survives packing and sign/zero extension unchanged.
  function automatic logic imm_in_range(input logic [1:0] fmt, input logic [31:0] imm);
    logic ok;
    case (imm_fmt_e'(fmt))
      FMT_I, FMT_S: ok = (&imm[31:11]) || !(|imm[31:11]);
      FMT_B:        ok = ((&imm[31:12]) || !(|imm[31:12])) && !imm[0];
      default:      ok = !(|imm[31:5]);
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/imm_pack_fields.sv
// rtl/imm_pack_fields.sv - combinational packing of fields and immediate into an RV32I word
module imm_pack_fields
  import imm_packer_pkg::*;
(
  input  logic [1:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic [31:0] instr,
  output logic        err
);

  always_comb begin
    instr = '0;
    case (imm_fmt_e'(fmt))
      FMT_I:   instr = {imm[11:0], rs1, funct3, rd, opcode};
      FMT_S:   instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      FMT_B:   instr = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      default: instr = {funct7, imm[4:0], rs1, funct3, rd, opcode};
    endcase
  end

  assign err = !imm_in_range(fmt, imm);

endmodule

// File: rtl/imm_packer.sv
// rtl/imm_packer.sv - two-stage valid/ready instruction packer with address counter and error count
module imm_packer
  import imm_packer_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_fmt,
  input  logic [6:0]        in_opcode,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_err,
  output logic [15:0]       err_count
);

  logic              s1_valid;
  logic [31:0]       s1_instr;
  logic              s1_err;
  logic [ADDR_W-1:0] s1_addr;
  logic [ADDR_W-1:0] addr_cnt;

  logic [31:0]       pack_instr;
  logic              pack_err;
  logic              s2_advance;
  logic              s1_advance;
  logic              accept;

  imm_pack_fields u_fields (
    .fmt    (in_fmt),
    .opcode (in_opcode),
    .funct3 (in_funct3),
    .funct7 (in_funct7),
    .rd     (in_rd),
    .rs1    (in_rs1),
    .rs2    (in_rs2),
    .imm    (in_imm),
    .instr  (pack_instr),
    .err    (pack_err)
  );

  assign s2_advance = !out_valid || out_ready;
  assign s1_advance = s2_advance || !out_valid;
  // Clear closes the input for its cycle so a coincident request is dropped.
  assign in_ready   = !clear && (!s1_valid || s1_advance);
  assign accept     = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_instr <= '0;
      s1_err   <= 1'b0;
      s1_addr  <= BASE_ADDR;
      addr_cnt <= BASE_ADDR;
    end else if (clear) begin
      s1_valid <= 1'b0;
      addr_cnt <= BASE_ADDR;
    end else begin
      if (!s1_valid || s1_advance) begin
        s1_valid <= in_valid;
      end
      if (accept) begin
        s1_instr <= pack_instr;
        s1_err   <= pack_err;
        s1_addr  <= addr_cnt;
        addr_cnt <= addr_cnt + ADDR_W'(4);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_instr <= '0;
      out_addr  <= BASE_ADDR;
      out_err   <= 1'b0;
    end else if (clear) begin
      out_valid <= 1'b0;
    end else if (s2_advance) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_instr <= s1_instr;
        out_addr  <= s1_addr;
        out_err   <= s1_err;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (clear) begin
      err_count <= '0;
    end else if (out_valid && out_ready && out_err && (err_count != ERR_COUNT_MAX)) begin
      err_count <= err_count + 16'd1;
    end
  end

endmodule
